// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use hazard
// detection and branch flush; feeds the ALU a, b, shamt and aluctrl inputs.
module ex_operand_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_aluctrl,
  input  logic [1:0]       id_alusrca,
  input  logic             id_alusrcb,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic [RADDR-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [XLEN-1:0]  mem_aluout,
  input  logic [RADDR-1:0] wb_rd,
  input  logic             wb_regwrite,
  input  logic [XLEN-1:0]  wb_wdata,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [4:0]       ex_shamt,
  output logic [3:0]       ex_aluctrl,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic [XLEN-1:0]  ex_storedata
);

  typedef enum logic [1:0] {
    SRCA_RS1   = 2'b00,
    SRCA_PC    = 2'b01,
    SRCA_ZERO  = 2'b10,
    SRCA_ZERO2 = 2'b11
  } srca_e;

  logic [RADDR-1:0] ex_rs1;
  logic [RADDR-1:0] ex_rs2;
  logic [XLEN-1:0]  ex_rd1;
  logic [XLEN-1:0]  ex_rd2;
  logic [XLEN-1:0]  ex_imm;
  srca_e            ex_alusrca;
  logic             ex_alusrcb;
  logic [XLEN-1:0]  rs1_fwd;
  logic [XLEN-1:0]  rs2_fwd;
  logic             load_use;
  logic             capture;

  // Conservative: rs2 is compared even when the ID instruction uses its immediate.
  assign load_use = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign stall_id = ~reset & load_use & ~flush;
  assign capture  = ~flush & ~stall_id;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
    end else if (capture) begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_valid & id_regwrite;
      ex_memread  <= id_valid & id_memread;
    end else begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
    end
  end

  // NOTE: the data fields are plain flops (not a memory), so they carry a
  // reset like the control bits; that keeps ex_a/ex_b at 0 while in reset.
  // A bubble leaves them holding stale data, which is harmless once ex_valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_aluctrl <= '0;
      ex_alusrca <= SRCA_RS1;
      ex_alusrcb <= 1'b0;
    end else if (capture) begin
      ex_pc      <= id_pc;
      ex_rs1     <= id_rs1;
      ex_rs2     <= id_rs2;
      ex_rd      <= id_rd;
      ex_rd1     <= id_rd1;
      ex_rd2     <= id_rd2;
      ex_imm     <= id_imm;
      ex_aluctrl <= id_aluctrl;
      ex_alusrca <= srca_e'(id_alusrca);
      ex_alusrcb <= id_alusrcb;
    end
  end

  // MEM beats WB; x0 is never forwarded, so the regfile's zero always wins there.
  function automatic logic [XLEN-1:0] forward(
    input logic [RADDR-1:0] rs,
    input logic [XLEN-1:0]  rf_data,
    input logic [RADDR-1:0] m_rd,
    input logic             m_we,
    input logic [XLEN-1:0]  m_data,
    input logic [RADDR-1:0] w_rd,
    input logic             w_we,
    input logic [XLEN-1:0]  w_data
  );
    if (rs == '0)                 return rf_data;
    else if (m_we && m_rd == rs)  return m_data;
    else if (w_we && w_rd == rs)  return w_data;
    else                          return rf_data;
  endfunction

  assign rs1_fwd = forward(ex_rs1, ex_rd1, mem_rd, mem_regwrite, mem_aluout,
                           wb_rd, wb_regwrite, wb_wdata);
  assign rs2_fwd = forward(ex_rs2, ex_rd2, mem_rd, mem_regwrite, mem_aluout,
                           wb_rd, wb_regwrite, wb_wdata);

  // NOTE: every output of this always_comb gets a default before any branch,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    ex_a = '0;
    ex_b = '0;
    if (!reset) begin
      unique case (ex_alusrca)
        SRCA_RS1: ex_a = rs1_fwd;
        SRCA_PC:  ex_a = ex_pc;
        default:  ex_a = '0;
      endcase
      ex_b = ex_alusrcb ? ex_imm : rs2_fwd;
    end
  end

  assign ex_shamt     = ex_b[4:0];
  assign ex_storedata = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: each accepted ID instruction pushes its
// expected EX operands, popped and compared one edge later.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  aluctrl;
    logic [1:0]  alusrca;
    logic        alusrcb, regwrite, memread;
  } instr_t;

  typedef struct packed {
    logic [4:0]  mem_rd;
    logic        mem_rw;
    logic [31:0] mem_out;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [31:0] wb_data;
  } ctx_t;

  typedef struct {
    instr_t      i;
    ctx_t        c;
    logic [31:0] a, b, sd;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_aluctrl;
  logic [1:0]  id_alusrca;
  logic        id_alusrcb, id_regwrite, id_memread, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_regwrite, wb_regwrite;
  logic [31:0] mem_aluout, wb_wdata;
  logic        stall_id, ex_valid, ex_regwrite, ex_memread;
  logic [31:0] ex_pc, ex_a, ex_b, ex_storedata;
  logic [4:0]  ex_shamt, ex_rd;
  logic [3:0]  ex_aluctrl;

  int total = 0;
  int bad   = 0;

  sb_t        sb[$];
  logic       m_valid = 1'b0;
  logic       m_memread = 1'b0;
  logic [4:0] m_rd = '0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_aluctrl(id_aluctrl),
    .id_alusrca(id_alusrca), .id_alusrcb(id_alusrcb),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_aluout(mem_aluout),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_wdata(wb_wdata),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a),
    .ex_b(ex_b), .ex_shamt(ex_shamt), .ex_aluctrl(ex_aluctrl), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_storedata(ex_storedata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf, input ctx_t c);
    logic [31:0] v;
    v = rf;
    if (rs != 5'd0) begin
      if (c.wb_rw && c.wb_rd == rs)   v = c.wb_data;
      if (c.mem_rw && c.mem_rd == rs) v = c.mem_out;
    end
    return v;
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                                input logic [31:0] rd1, rd2, imm, input logic [1:0] srca,
                                input logic srcb, rw, mr);
    instr_t t;
    t.valid = 1'b1; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.rd1 = rd1; t.rd2 = rd2; t.imm = imm; t.aluctrl = pc[5:2];
    t.alusrca = srca; t.alusrcb = srcb; t.regwrite = rw; t.memread = mr;
    return t;
  endfunction

  function automatic ctx_t mkc(input logic [4:0] mrd, input logic mrw, input logic [31:0] mout,
                               input logic [4:0] wrd, input logic wrw, input logic [31:0] wdat);
    ctx_t c;
    c.mem_rd = mrd; c.mem_rw = mrw; c.mem_out = mout;
    c.wb_rd = wrd; c.wb_rw = wrw; c.wb_data = wdat;
    return c;
  endfunction

  // Drive an ID instruction; c is the forwarding context it will see once in EX.
  task automatic present(input instr_t ins, input ctx_t c, input logic fl, output logic stalled);
    logic exp_stall;
    sb_t  e;
    id_valid = ins.valid; id_pc = ins.pc; id_rs1 = ins.rs1; id_rs2 = ins.rs2;
    id_rd = ins.rd; id_rd1 = ins.rd1; id_rd2 = ins.rd2; id_imm = ins.imm;
    id_aluctrl = ins.aluctrl; id_alusrca = ins.alusrca; id_alusrcb = ins.alusrcb;
    id_regwrite = ins.regwrite; id_memread = ins.memread; flush = fl;
    #1;
    exp_stall = ins.valid && m_valid && m_memread && m_rd != 5'd0 &&
                (m_rd == ins.rs1 || m_rd == ins.rs2) && !fl;
    check("stall_id", {31'd0, stall_id}, {31'd0, exp_stall});
    stalled = exp_stall;
    if (fl || exp_stall || !ins.valid) begin
      m_valid = 1'b0; m_memread = 1'b0;
    end else begin
      m_valid = 1'b1; m_memread = ins.memread; m_rd = ins.rd;
      e.i  = ins;
      e.c  = c;
      e.sd = model_fwd(ins.rs2, ins.rd2, c);
      e.a  = (ins.alusrca == 2'b00) ? model_fwd(ins.rs1, ins.rd1, c) :
             (ins.alusrca == 2'b01) ? ins.pc : 32'd0;
      e.b  = ins.alusrcb ? ins.imm : e.sd;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
        #1;
      end else begin
        e = sb.pop_front();
        mem_rd = e.c.mem_rd; mem_regwrite = e.c.mem_rw; mem_aluout = e.c.mem_out;
        wb_rd = e.c.wb_rd; wb_regwrite = e.c.wb_rw; wb_wdata = e.c.wb_data;
        #1;
        check("ex_valid", {31'd0, ex_valid}, 32'd1);
        check("ex_pc", ex_pc, e.i.pc);
        check("ex_a", ex_a, e.a);
        check("ex_b", ex_b, e.b);
        check("ex_shamt", {27'd0, ex_shamt}, {27'd0, e.b[4:0]});
        check("ex_storedata", ex_storedata, e.sd);
        check("ex_aluctrl", {28'd0, ex_aluctrl}, {28'd0, e.i.aluctrl});
        check("ex_rd", {27'd0, ex_rd}, {27'd0, e.i.rd});
        check("ex_regwrite", {31'd0, ex_regwrite}, {31'd0, e.i.regwrite});
        check("ex_memread", {31'd0, ex_memread}, {31'd0, e.i.memread});
      end
    end else begin
      #1;
      check("bubble_valid", {31'd0, ex_valid}, 32'd0);
      check("bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);
      check("bubble_memread", {31'd0, ex_memread}, 32'd0);
    end
  endtask

  initial begin
    instr_t ins;
    ctx_t   c, nc;
    logic   st;
    reset = 1'b1; flush = 1'b0;
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_aluctrl = '0; id_alusrca = '0;
    id_alusrcb = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_aluout = '0;
    wb_rd = '0; wb_regwrite = 1'b0; wb_wdata = '0;
    nc = mkc(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    #3;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_a", ex_a, 32'd0);
    check("rst_stall", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // T2: MEM and WB both match rs1; MEM wins, then WB once MEM drops
    ins = mk(32'h40, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h7, 2'b00, 1'b1, 1'b1, 1'b0);
    present(ins, mkc(5'd1, 1'b1, 32'h10, 5'd1, 1'b1, 32'h20), 1'b0, st);
    tick();
    mem_regwrite = 1'b0;
    #1;
    check("t2_wb_fwd", ex_a, 32'h20);

    // T4: x0 is never forwarded
    ins = mk(32'h44, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    present(ins, mkc(5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF), 1'b0, st);
    tick();

    // T6: auipc operand selection
    ins = mk(32'h100, 5'd7, 5'd8, 5'd9, 32'h11, 32'h22, 32'h1000, 2'b01, 1'b1, 1'b1, 1'b0);
    present(ins, nc, 1'b0, st);
    tick();

    // T3: lw x5 then add x6,x5,x0 -> one bubble, then WB forward
    ins = mk(32'h200, 5'd2, 5'd0, 5'd5, 32'h80, 32'h0, 32'h4, 2'b00, 1'b1, 1'b1, 1'b1);
    present(ins, nc, 1'b0, st);
    tick();
    ins = mk(32'h204, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    c = mkc(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'hCAFE);
    present(ins, c, 1'b0, st);
    check("t3_stall_first", {31'd0, st}, 32'd1);
    tick();
    present(ins, c, 1'b0, st);
    check("t3_stall_once", {31'd0, st}, 32'd0);
    tick();

    // T5: flush overrides a load-use stall
    ins = mk(32'h300, 5'd1, 5'd0, 5'd5, 32'h90, 32'h0, 32'h8, 2'b00, 1'b1, 1'b1, 1'b1);
    present(ins, nc, 1'b0, st);
    tick();
    ins = mk(32'h304, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    present(ins, nc, 1'b1, st);
    tick();

    // T1: reset asserted between edges clears EX immediately
    ins = mk(32'h400, 5'd3, 5'd4, 5'd10, 32'h33, 32'h44, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    present(ins, nc, 1'b0, st);
    tick();
    ins = mk(32'h404, 5'd3, 5'd4, 5'd11, 32'h55, 32'h66, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    present(ins, nc, 1'b0, st);
    reset = 1'b1;
    #1;
    check("t1_valid", {31'd0, ex_valid}, 32'd0);
    check("t1_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("t1_a", ex_a, 32'd0);
    check("t1_b", ex_b, 32'd0);
    reset = 1'b0;
    sb.delete();
    m_valid = 1'b0; m_memread = 1'b0;
    ins = mk(32'h500, 5'd12, 5'd13, 5'd14, 32'h77, 32'h88, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    present(ins, nc, 1'b0, st);
    tick();

    // Random mix; a stalled instruction is re-presented as ID would hold it
    st = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (!st) begin
        ins = mk($urandom, 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                 5'($urandom_range(0, 6)), $urandom, $urandom, $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        ins.valid = ($urandom_range(0, 5) != 0);
        c = mkc(5'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom,
                5'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom);
      end
      present(ins, c, ($urandom_range(0, 9) == 0), st);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
